// File: rtl/data_sram_resp_pkg.sv
// Shared widths, FSM encoding and address helpers
// for the data-SRAM responder.
package data_sram_resp_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_WEN_W  = 4;
    localparam int DMEM_LAT_W  = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Full-word accesses (reads and wen=F writes) must be
    // word aligned; partial-lane writes may sit anywhere.
    function automatic logic dmem_misaligned(
        input logic [DMEM_ADDR_W-1:0] addr,
        input logic [DMEM_WEN_W-1:0]  wen
    );
        return (addr[1:0] != 2'b00) &&
               ((wen == 4'b0000) || (wen == 4'b1111));
    endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data-SRAM bus between the execute stage (master)
// and the data-memory responder (slave).
interface data_sram_resp_if;
    import data_sram_resp_pkg::*;

    logic                   data_sram_en;
    logic [DMEM_WEN_W-1:0]  data_sram_wen;
    logic [DMEM_ADDR_W-1:0] data_sram_addr;
    logic [DMEM_DATA_W-1:0] data_sram_wdata;
    logic [DMEM_DATA_W-1:0] data_sram_rdata;
    logic                   rdata_valid;
    logic                   stallreq_from_dmem;
    logic                   addr_err;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  rdata_valid,
        input  stallreq_from_dmem,
        input  addr_err
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output rdata_valid,
        output stallreq_from_dmem,
        output addr_err
    );

endinterface

// File: rtl/data_sram_resp_dmem_array.sv
// Word-organised data storage with byte-lane writes.
// Not reset: contents survive a pipeline reset.
module data_sram_resp_dmem_array
    import data_sram_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [DMEM_WEN_W-1:0]  wen,
    input  logic [DMEM_DATA_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH];

    // Single write port; lanes with wen[i]=0 keep their byte.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DMEM_WEN_W; i++) begin
                if (wen[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read word is sampled into the owner's output register
    // on the response edge, giving a synchronous read port.
    assign rdata = mem[raddr];

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: posted writes, reads with a
// configurable latency and a stall request while pending.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic            clk,
    input  logic            rst,
    data_sram_resp_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [DMEM_LAT_W-1:0] CNT_INIT =
        DMEM_LAT_W'(LATENCY - 1);
    localparam logic [DMEM_LAT_W-1:0] CNT_ONE =
        DMEM_LAT_W'(1);

    typedef struct packed {
        logic          err;
        logic [AW-1:0] word;
    } cap_t;

    dmem_state_e            state_q, state_d;
    logic [DMEM_LAT_W-1:0]  cnt_q, cnt_d;
    cap_t                   cap_q, cap_d;
    logic [DMEM_DATA_W-1:0] rdata_q, rdata_d;
    logic                   valid_q, valid_d;
    logic                   stall_q, stall_d;
    logic                   err_q, err_d;

    logic [29:0]            word;
    logic                   out_rng;
    logic                   bad;
    logic                   req;
    logic                   wr_en;
    logic [AW-1:0]          raddr;
    logic [DMEM_DATA_W-1:0] arr_rdata;

    assign word = 30'((bus.data_sram_addr - BASE_ADDR) >> 2);

    assign out_rng = (bus.data_sram_addr < BASE_ADDR) ||
                     ({2'b00, word} >= DEPTH_W);

    assign bad = out_rng ||
                 dmem_misaligned(bus.data_sram_addr,
                                 bus.data_sram_wen);

    assign req = bus.data_sram_en && (state_q == DMEM_IDLE);

    // Held off while reset is low so a stray strobe cannot
    // corrupt the preserved array contents.
    assign wr_en = rst && req &&
                   (bus.data_sram_wen != '0) && !bad;

    // In IDLE only the single-cycle read uses the port, so the
    // live address is selected; otherwise the captured one.
    assign raddr = (state_q == DMEM_IDLE) ? word[AW-1:0]
                                          : cap_q.word;

    data_sram_resp_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (word[AW-1:0]),
        .wen   (bus.data_sram_wen),
        .wdata (bus.data_sram_wdata),
        .raddr (raddr),
        .rdata (arr_rdata)
    );

    // Next-state and next-output decode; every output is
    // registered, so this only computes the D side.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        stall_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            DMEM_IDLE: begin
                if (bus.data_sram_en) begin
                    err_d = bad;
                    if (bus.data_sram_wen == '0) begin
                        cap_d.err  = bad;
                        cap_d.word = word[AW-1:0];
                        cnt_d      = CNT_INIT;
                        if (LATENCY == 1) begin
                            state_d = DMEM_RESP;
                            valid_d = 1'b1;
                            rdata_d = bad ? '0 : arr_rdata;
                        end else begin
                            state_d = DMEM_WAIT;
                            stall_d = 1'b1;
                        end
                    end
                end
            end
            DMEM_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DMEM_RESP;
                    valid_d = 1'b1;
                    rdata_d = cap_q.err ? '0 : arr_rdata;
                end else begin
                    stall_d = 1'b1;
                end
            end
            DMEM_RESP: begin
                state_d = DMEM_IDLE;
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    // State, counter, capture and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_sram_rdata    = rdata_q;
    assign bus.rdata_valid        = valid_q;
    assign bus.stallreq_from_dmem = stall_q;
    assign bus.addr_err           = err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomised bench for data_sram_resp at three latencies
// against a word-array reference model.
module tb_data_sram_resp;

    localparam int          DEP0 = 64;
    localparam int          DEP1 = 64;
    localparam int          DEP2 = 32;
    localparam logic [31:0] BAS0 = 32'h0000_0000;
    localparam logic [31:0] BAS1 = 32'h0000_0100;
    localparam logic [31:0] BAS2 = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          sel = 0;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] o_rdata;
    logic        o_valid;
    logic        o_stall;
    logic        o_err;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mdl [3][64];

    data_sram_resp_if b0();
    data_sram_resp_if b1();
    data_sram_resp_if b2();

    assign b0.data_sram_en = en && (sel == 0);
    assign b1.data_sram_en = en && (sel == 1);
    assign b2.data_sram_en = en && (sel == 2);
    assign b0.data_sram_wen = wen;
    assign b1.data_sram_wen = wen;
    assign b2.data_sram_wen = wen;
    assign b0.data_sram_addr = addr;
    assign b1.data_sram_addr = addr;
    assign b2.data_sram_addr = addr;
    assign b0.data_sram_wdata = wdata;
    assign b1.data_sram_wdata = wdata;
    assign b2.data_sram_wdata = wdata;

    data_sram_resp #(
        .DEPTH(DEP0), .BASE_ADDR(BAS0), .LATENCY(1)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(b0));

    data_sram_resp #(
        .DEPTH(DEP1), .BASE_ADDR(BAS1), .LATENCY(4)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

    data_sram_resp #(
        .DEPTH(DEP2), .BASE_ADDR(BAS2), .LATENCY(8)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    always_comb begin
        o_rdata = b0.data_sram_rdata;
        o_valid = b0.rdata_valid;
        o_stall = b0.stallreq_from_dmem;
        o_err   = b0.addr_err;
        case (sel)
            1: begin
                o_rdata = b1.data_sram_rdata;
                o_valid = b1.rdata_valid;
                o_stall = b1.stallreq_from_dmem;
                o_err   = b1.addr_err;
            end
            2: begin
                o_rdata = b2.data_sram_rdata;
                o_valid = b2.rdata_valid;
                o_stall = b2.stallreq_from_dmem;
                o_err   = b2.addr_err;
            end
            default: ;
        endcase
    end

    function automatic int lat_of(input int d);
        case (d)
            0: return 1;
            1: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int d);
        case (d)
            0: return BAS0;
            1: return BAS1;
            default: return BAS2;
        endcase
    endfunction

    function automatic int depth_of(input int d);
        case (d)
            0: return DEP0;
            1: return DEP1;
            default: return DEP2;
        endcase
    endfunction

    function automatic bit is_bad(input int d,
                                  input logic [31:0] a,
                                  input logic [3:0] w);
        logic [31:0] b;
        b = base_of(d);
        if (a < b) return 1'b1;
        if ((a - b) / 32'd4 >= 32'(depth_of(d))) return 1'b1;
        if ((w == 4'h0 || w == 4'hF) && (a % 32'd4 != 32'd0))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic int widx(input int d,
                                input logic [31:0] a);
        return int'((a - base_of(d)) / 32'd4);
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input int d,
                            input logic [31:0] a,
                            input logic [3:0] w,
                            input logic [31:0] data);
        bit bad;
        int i;
        bad = is_bad(d, a, w);
        @(negedge clk);
        sel = d; en = 1'b1; wen = w; addr = a; wdata = data;
        @(posedge clk);
        #1;
        en = 1'b0; wen = 4'h0;
        check("wr_err", 32'(o_err), 32'(bad));
        check("wr_stall", 32'(o_stall), 32'd0);
        check("wr_valid", 32'(o_valid), 32'd0);
        if (!bad) begin
            i = widx(d, a);
            for (int b = 0; b < 4; b++)
                if (w[b]) mdl[d][i][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic do_read(input int d,
                           input logic [31:0] a,
                           input int noise);
        bit bad;
        int l;
        logic [31:0] exp;
        l = lat_of(d);
        bad = is_bad(d, a, 4'h0);
        exp = 32'h0;
        if (!bad) exp = mdl[d][widx(d, a)];
        @(negedge clk);
        sel = d; en = 1'b1; wen = 4'h0; addr = a;
        for (int j = 1; j <= l; j++) begin
            @(posedge clk);
            #1;
            check("rd_err", 32'(o_err), 32'(bad && j == 1));
            check("rd_stall", 32'(o_stall), 32'(j < l));
            check("rd_valid", 32'(o_valid), 32'(j == l));
            if (j == l) check("rd_data", o_rdata, exp);
            en = (noise == 2) ? 1'b1 :
                 (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            wen = 4'($urandom);
            addr = base_of(d) +
                   32'(4 * $urandom_range(0, depth_of(d) - 1));
            wdata = $urandom;
        end
        @(posedge clk);
        #1;
        en = 1'b0; wen = 4'h0;
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_stall", 32'(o_stall), 32'd0);
        check("idle_err", 32'(o_err), 32'd0);
        check("rd_hold", o_rdata, exp);
    endtask

    task automatic do_reset_test();
        int vcnt;
        int scnt;
        do_write(2, 32'h40, 4'hF, 32'hCAFE_F00D);
        do_read(2, 32'h40, 0);
        @(negedge clk);
        sel = 2; en = 1'b1; wen = 4'h0; addr = 32'h44;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("rst_pre_stall1", 32'(o_stall), 32'd1);
        @(posedge clk);
        #1;
        check("rst_pre_stall2", 32'(o_stall), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        vcnt = 0;
        scnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (o_valid) vcnt++;
            if (o_stall) scnt++;
        end
        check("rst_no_valid", 32'(vcnt), 32'd0);
        check("rst_no_stall", 32'(scnt), 32'd0);
        do_read(2, 32'h40, 0);
        check("rst_preserved", o_rdata, 32'hCAFE_F00D);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        int r;
        int i;
        logic [31:0] a;
        logic [3:0] w;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check("reset_rdata", o_rdata, 32'd0);
            check("reset_valid", 32'(o_valid), 32'd0);
            check("reset_stall", 32'(o_stall), 32'd0);
            check("reset_err", 32'(o_err), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 3; k++)
            for (int j = 0; j < depth_of(k); j++)
                do_write(k, base_of(k) + 32'(4 * j),
                         4'hF, $urandom);

        do_write(0, 32'h10, 4'hF, 32'hDEAD_BEEF);
        do_read(0, 32'h10, 0);
        check("tp_deadbeef", o_rdata, 32'hDEAD_BEEF);

        do_write(0, 32'h20, 4'hF, 32'h1122_3344);
        do_write(0, 32'h20, 4'b0101, 32'hAABB_CCDD);
        do_read(0, 32'h20, 0);
        check("tp_lanes", o_rdata, 32'h11BB_33DD);

        do_write(1, 32'h110, 4'hF, 32'h0BAD_F00D);
        do_read(1, 32'h110, 2);
        check("tp_lat4", o_rdata, 32'h0BAD_F00D);

        do_read(1, 32'h113, 2);
        check("tp_misal_rd", o_rdata, 32'd0);
        do_read(1, 32'h0FC, 0);
        do_read(1, 32'h200, 0);
        do_write(0, 32'h100, 4'hF, 32'h5555_AAAA);
        do_read(0, 32'h0, 0);
        do_write(0, 32'h22, 4'hF, 32'h7777_7777);
        do_write(0, 32'h22, 4'b0011, 32'h1234_5678);
        do_read(0, 32'h20, 1);

        do_reset_test();

        for (int n = 0; n < 150; n++) begin
            d = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            i = $urandom_range(0, depth_of(d) - 1);
            a = base_of(d) + 32'(4 * i);
            if (r == 7) a = a + 32'($urandom_range(1, 3));
            if (r == 8) a = base_of(d) + 32'(4 * depth_of(d));
            if (r == 9) a = base_of(d) - 32'd4;
            if ($urandom_range(0, 1) == 0) begin
                do_read(d, a, $urandom_range(0, 2));
            end else begin
                w = 4'($urandom_range(1, 15));
                do_write(d, a, w, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
